// File: rtl/imm_ext_pipe.sv
// ---------------------------------------------------------------------------
// imm_ext_pipe
//
// Decode-stage immediate extender with a valid/ready input, a one-cycle
// registered output and a two-entry skid buffer. The immediate is extended
// combinationally on the input side, so both storage entries hold the final
// {ImmExt, ImmIllegal} pair rather than the raw instruction word.
//
// Parameters
//   XLEN        datapath width, 32 or 64
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset, discards all held entries
//   flush       synchronous flush, discards held entries and same-cycle input
//   in_valid    Instr/ImmSrc valid this cycle
//   in_ready    block can accept an input this cycle
//   Instr       32-bit instruction word
//   ImmSrc      immediate type code (3'b111 is illegal)
//   out_valid   ImmExt/ImmIllegal valid
//   out_ready   consumer accepts the output this cycle
//   ImmExt      extended immediate, XLEN bits
//   ImmIllegal  set when the entry was produced from ImmSrc 3'b111
// ---------------------------------------------------------------------------
module imm_ext_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic            ImmIllegal
);

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_U  = 3'b011;
  localparam logic [2:0] IMM_J  = 3'b100;
  localparam logic [2:0] IMM_Z  = 3'b101;
  localparam logic [2:0] IMM_SH = 3'b110;

  // Opcode field never contributes to any immediate.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[6:0];

  // -------------------------------------------------------------------------
  // Combinational extension
  // -------------------------------------------------------------------------
  logic [31:0]     imm_lo;     // low 32 bits of the result
  logic            sext_en;    // replicate Instr[31] above bit 31
  logic [XLEN-1:0] ext_imm;
  logic            ext_ill;

  always_comb begin
    imm_lo  = '0;
    sext_en = 1'b1;
    ext_ill = 1'b0;
    case (ImmSrc)
      IMM_I:  imm_lo = {{20{Instr[31]}}, Instr[31:20]};
      IMM_S:  imm_lo = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_B:  imm_lo = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                        Instr[11:8], 1'b0};
      IMM_U:  imm_lo = {Instr[31:12], 12'b0};
      IMM_J:  imm_lo = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                        Instr[30:21], 1'b0};
      IMM_Z: begin
        imm_lo  = {27'b0, Instr[19:15]};
        sext_en = 1'b0;
      end
      IMM_SH: begin
        // RV64 shift amounts carry one extra bit (Instr[25]).
        imm_lo  = {26'b0, (XLEN == 64) ? Instr[25] : 1'b0, Instr[24:20]};
        sext_en = 1'b0;
      end
      default: begin
        imm_lo  = '0;
        sext_en = 1'b0;
        ext_ill = 1'b1;
      end
    endcase
    // Upper bits (if any) are sign fill; for XLEN=32 this line is fully
    // overwritten by the next one.
    ext_imm        = {XLEN{sext_en & Instr[31]}};
    ext_imm[31:0]  = imm_lo;
  end

  // -------------------------------------------------------------------------
  // Output register (O) and skid register (S)
  // -------------------------------------------------------------------------
  logic            o_valid_q, o_valid_d;
  logic [XLEN-1:0] o_imm_q,   o_imm_d;
  logic            o_ill_q,   o_ill_d;
  logic            s_valid_q, s_valid_d;
  logic [XLEN-1:0] s_imm_q,   s_imm_d;
  logic            s_ill_q,   s_ill_d;

  logic accept;
  logic pop;

  // in_ready depends only on state plus reset/flush, never on out_ready,
  // which is what makes S necessary: one extra beat may arrive after the
  // consumer stalls.
  assign in_ready = ~s_valid_q & ~reset & ~flush;
  assign accept   = in_valid & in_ready;
  assign pop      = o_valid_q & out_ready;

  always_comb begin
    o_valid_d = o_valid_q;
    o_imm_d   = o_imm_q;
    o_ill_d   = o_ill_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_ill_d   = s_ill_q;

    if (flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (pop && s_valid_q) begin
      // S full implies in_ready was low, so no accept can coincide.
      o_imm_d   = s_imm_q;
      o_ill_d   = s_ill_q;
      s_valid_d = 1'b0;
    end else if (accept && (!o_valid_q || pop)) begin
      o_valid_d = 1'b1;
      o_imm_d   = ext_imm;
      o_ill_d   = ext_ill;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_imm_d   = ext_imm;
      s_ill_d   = ext_ill;
    end else if (pop) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid_q <= 1'b0;
      o_imm_q   <= '0;
      o_ill_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_imm_q   <= '0;
      s_ill_q   <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_imm_q   <= o_imm_d;
      o_ill_q   <= o_ill_d;
      s_valid_q <= s_valid_d;
      s_imm_q   <= s_imm_d;
      s_ill_q   <= s_ill_d;
    end
  end

  assign out_valid  = o_valid_q;
  assign ImmExt     = o_imm_q;
  assign ImmIllegal = o_ill_q;

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate extender for the decode stage. It accepts an instruction word and an immediate-type code over a valid/ready handshake and presents the extended immediate one cycle later through a two-entry skid buffer, so decode backpressure never corrupts in-flight data. It supports XLEN = 32 or 64, adds CSR-zimm and shift-amount formats, flags illegal type codes, and supports a synchronous flush for redirects.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64 only.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  Instr/ImmSrc are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- Instr  input  32  instruction word.
- ImmSrc  input  3  immediate type code.
- out_valid  output  1  ImmExt/ImmIllegal are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- ImmExt  output  XLEN  extended immediate.
- ImmIllegal  output  1  ImmSrc was 3'b111.

## Operation
- ImmSrc formats; "sext" means sign-extend from Instr[31] to XLEN:
  - 000 I: sext(Instr[31:20]).
  - 001 S: sext({Instr[31:25], Instr[11:7]}).
  - 010 B: sext({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}).
  - 011 U: sext({Instr[31:12], 12'b0}). For XLEN=64, bits 63:32 are copies of Instr[31].
  - 100 J: sext({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}).
  - 101 Z: zero-extend Instr[19:15], the CSR zimm.
  - 110 SH: zero-extend Instr[24:20] when XLEN=32; zero-extend Instr[25:20] when XLEN=64.
  - 111: ImmExt = 0 and ImmIllegal = 1. For every other code, ImmIllegal = 0.
- Extension is combinational on the input side. Both storage entries hold the computed {ImmExt, ImmIllegal}, not the raw Instr.
- Storage has two entries:
  - Output register (O) drives out_valid, ImmExt and ImmIllegal.
  - Skid register (S) is internal.
- in_ready = ~S.valid & ~reset & ~flush. It is derived only from state and these two inputs, with no combinational path from out_ready.
- Accept event: in_valid & in_ready. Pop event: out_valid & out_ready.
- Per-cycle update when there is no reset and no flush:
  - Pop and S.valid: O <= S, S.valid <= 0. No accept is possible in this case.
  - Accept, and either O empty or pop: O <= new data.
  - Accept, O full, no pop: S <= new data. S.valid <= 1.
  - Pop with no accept and S empty: O.valid <= 0.
- Ordering is strict FIFO. Data is never dropped or duplicated.
- flush has priority over everything except reset. It clears O.valid and S.valid, and any input presented in the same cycle is discarded.
- reset clears O.valid and S.valid, sets ImmExt = 0 and ImmIllegal = 0, and forces in_ready = 0 while asserted. Asserting reset mid-transfer discards all held entries.

## Timing
- Latency is 1 cycle: an input accepted at edge N is visible on the outputs after edge N, provided O was empty or popping at edge N.
- Sustained throughput is 1 per cycle while out_ready = 1.
- When out_ready falls, the block absorbs exactly one more accepted input into S. in_ready then goes low in the next cycle.
- in_ready returns high on the cycle after S drains into O.
- ImmExt and ImmIllegal hold their value while out_valid = 1 and out_ready = 0. Their values are don't-care while out_valid = 0.
- out_valid is 0 on the first cycle after reset or flush is released.

## Test plan
- Format coverage at XLEN=32 with out_ready=1. Each result must appear 1 cycle after accept:
  - Instr 0xFFF00093, ImmSrc 000 -> ImmExt 0xFFFFFFFF.
  - Instr 0xFE112E23, ImmSrc 001 -> ImmExt 0xFFFFFFFC.
  - Instr 0xFE000FE3, ImmSrc 010 -> ImmExt 0xFFFFFFFE.
  - Instr 0x123450B7, ImmSrc 011 -> ImmExt 0x12345000.
- XLEN=64 formats:
  - Instr 0x80000037, ImmSrc 011 -> ImmExt 0xFFFFFFFF80000000.
  - Instr 0x03F01013, ImmSrc 110 -> ImmExt 0x3F.
  - Instr 0x000FD073, ImmSrc 101 -> ImmExt 0x1F.
- Illegal code: ImmSrc 111 with any Instr -> ImmExt 0 and ImmIllegal 1. The following ImmSrc 000 input -> ImmIllegal 0.
- Backpressure: stream A, B, C, D back-to-back and hold out_ready=0 from cycle 2.
  - in_ready drops after B lands in S.
  - Raising out_ready then yields A, B, C, D in order, with none lost or duplicated.
- Flush with both entries full and in_valid=1 in the same cycle:
  - Next cycle: out_valid=0, in_ready=1.
  - The flushed-cycle input never appears on the outputs.
- Reset mid-stream with O and S full:
  - Next cycle: out_valid=0, ImmExt=0, ImmIllegal=0.
  - in_ready=0 while reset is high and 1 on the first cycle after reset.
